// File: rtl/serial_fa_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped LSB-first over
// WIDTH cycles, with a carry register linking consecutive bit positions.

module fa_dataflow (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_fa_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             done_q, done_d;
   logic             fa_s, fa_co;

   fa_dataflow u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      part_d  = part_q;
      carry_d = carry_q;
      s_d     = s_q;
      co_d    = co_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Subtraction is a + ~b + 1: invert B and force the initial carry.
               state_d = ST_RUN;
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : ci;
               cnt_d   = '0;
               part_d  = '0;
            end
         end
         ST_RUN: begin
            part_d  = {fa_s, part_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               s_d     = {fa_s, part_q[WIDTH-1:1]};
               co_d    = fa_co;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         part_q  <= part_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         co_q    <= co_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign s    = s_q;
   assign co   = co_q;
endmodule

// File: doc/serial_fa_ctrl.md
Name: serial_fa_ctrl

Overview:
- Bit-serial add/subtract controller that time-shares a single full-adder cell across all bit positions of a WIDTH-bit operation.
- Accepts a start request with operands, then steps the full-adder cell LSB-first for WIDTH cycles, carrying between steps through a carry register.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits between a requesting sequencer and the full-adder datapath (fa_dataflow cell instantiated internally, one instance only).

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+ci; 1 = a-b, computed as a+~b+1 (ci ignored); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ci  input  1  carry-in for add mode; sampled with start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse; s/co valid from this cycle.
- s  output  WIDTH  result, registered; holds last result.
- co  output  1  final carry-out (sub mode: 1 = no borrow), registered.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, s=0, co=0, bit counter=0, operand/result shift registers=0, carry register=0. Takes effect immediately, independent of clk.
- FSM states: IDLE, RUN.
  - IDLE: if start=1 at an edge, go to RUN.
    - Latch a into the A shift register.
    - Latch b into the B shift register, or ~b if sub=1.
    - Set the carry register to ci, or 1 if sub=1.
    - Clear the counter and clear the partial-result register.
  - RUN: each edge feeds A[0], B[0] and the carry register to the full-adder cell, then:
    - Shift the sum bit into the partial-result MSB (shift right).
    - Shift A and B right by one.
    - Carry register <= cell co.
    - Counter increments.
  - RUN exit: on the edge that processes bit WIDTH-1 (counter == WIDTH-1):
    - s <= final partial result and co <= cell co.
    - done <= 1, state <= IDLE.
- Latency: with the start-sampling edge as E0, bit k is processed at edge E(k+1).
  - done is high for exactly the one cycle following edge E(WIDTH).
  - busy is high from E0 to E(WIDTH): exactly WIDTH cycles.
- done is a pulse; it is deasserted at the next edge unconditionally.
- Back-to-back: start may be asserted during the done cycle; it is accepted (state is IDLE), giving throughput of one operation per WIDTH+1 cycles minimum.
- start while busy=1: ignored; in-flight operands unaffected; no queueing.
- a, b, sub, ci may change freely while busy; only the values at the accepting edge matter.
- s/co are not cleared on start; they change only at completion or reset.
- Arithmetic: result is modulo 2^WIDTH; co is the true carry out of bit WIDTH-1.
- Reset mid-operation: operation aborted, no done pulse, s/co return to 0.
- Counter width is clog2(WIDTH); the counter never exceeds WIDTH-1.

Test Plan:
1. WIDTH=8, start with a=8'h35, b=8'h4A, ci=0, sub=0 -> busy high for 8 cycles; done pulses 8 clocks after the start edge; s=8'h7F, co=0.
2. a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1. Then a=8'hFF, b=8'h00, ci=1 -> s=8'h00, co=1.
3. sub=1: a=8'h10, b=8'h01 -> s=8'h0F, co=1. Then a=8'h01, b=8'h02, with ci=0 driven -> s=8'hFF, co=0.
4. Assert start with a=8'h11, b=8'h22 at cycle 3 of a running 8'h01+8'h01 operation -> ignored; result s=8'h02. Start asserted in the done cycle -> accepted; second result valid 9 clocks after the first done.
5. Drop rst_n low between clock edges at RUN bit 4 -> busy, done, s and co go to 0 immediately (before the next edge); no done pulse. A subsequent start completes normally.
6. WIDTH=3: exhaustive sweep of all a, b, ci in add mode and all a, b in sub mode -> s/co match a+b+ci and a+~b+1 respectively for every vector; done count equals vector count.
